// File: rtl/dds_sweep_ctrl.sv
// Stepped linear frequency sweep sequencer driving a DDS core's frequency word and phase offset.
// Optional bidirectional (up/down) sweeps are enabled by defining DDS_SWEEP_BIDIR_EN.
module dds_sweep_ctrl #(
    parameter int FW = 24,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce_in,
    input  logic          start,
    input  logic          abort,
    input  logic [FW-1:0] f_start,
    input  logic [FW-1:0] f_stop,
    input  logic [FW-1:0] f_step,
    input  logic [DW-1:0] dwell,
    input  logic          repeat_en,
    input  logic [FW-1:0] phase_in,
`ifdef DDS_SWEEP_BIDIR_EN
    input  logic          bidir,
`endif
    output logic [FW-1:0] freqword,
    output logic [FW-1:0] phase_offset,
    output logic          busy,
    output logic          done,
    output logic          step_strobe,
    output logic [1:0]    state_dbg
);

    // start and abort are single-cycle pulses with no handshake: start is acted on only in
    // IDLE, abort in any other state, and abort wins when both arrive in the same cycle.
    typedef enum logic [1:0] {IDLE, DWELL, STEP, DONE} state_t;

    localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

    state_t        state, state_nxt;
    logic [FW-1:0] fw_nxt, ph_nxt;
    logic [DW-1:0] cnt, cnt_nxt;
    logic          strobe_nxt, load, end_sweep;
    logic [FW-1:0] start_sh, stop_sh, step_sh;
    logic [DW-1:0] dwell_sh, reload;
    logic          rep_sh;
    logic [FW:0]   up_sum;
    logic          up_ok;
`ifdef DDS_SWEEP_BIDIR_EN
    logic          bidir_sh, dir_down, dir_nxt;
    logic [FW:0]   dn_diff;
    logic          dn_ok;
`endif

    assign reload = (dwell_sh == '0) ? ONE : dwell_sh;
    // One extra bit so a step past the top of the range is caught as a carry, not a wrap.
    assign up_sum = {1'b0, freqword} + {1'b0, step_sh};
    assign up_ok  = !up_sum[FW] && (up_sum[FW-1:0] <= stop_sh);
`ifdef DDS_SWEEP_BIDIR_EN
    assign dn_diff = {1'b0, freqword} - {1'b0, step_sh};
    assign dn_ok   = !dn_diff[FW] && (dn_diff[FW-1:0] >= start_sh);
`endif

    assign busy      = (state == DWELL) || (state == STEP);
    assign done      = (state == DONE);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            freqword     <= '0;
            phase_offset <= '0;
            step_strobe  <= 1'b0;
            cnt          <= '0;
            start_sh     <= '0;
            stop_sh      <= '0;
            step_sh      <= '0;
            dwell_sh     <= '0;
            rep_sh       <= 1'b0;
`ifdef DDS_SWEEP_BIDIR_EN
            bidir_sh     <= 1'b0;
            dir_down     <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            freqword     <= fw_nxt;
            phase_offset <= ph_nxt;
            step_strobe  <= strobe_nxt;
            cnt          <= cnt_nxt;
`ifdef DDS_SWEEP_BIDIR_EN
            dir_down     <= dir_nxt;
`endif
            if (load) begin
                start_sh <= f_start;
                stop_sh  <= f_stop;
                step_sh  <= f_step;
                dwell_sh <= dwell;
                rep_sh   <= repeat_en;
`ifdef DDS_SWEEP_BIDIR_EN
                bidir_sh <= bidir;
`endif
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        fw_nxt     = freqword;
        ph_nxt     = phase_offset;
        cnt_nxt    = cnt;
        strobe_nxt = 1'b0;
        load       = 1'b0;
        end_sweep  = 1'b0;
`ifdef DDS_SWEEP_BIDIR_EN
        dir_nxt    = dir_down;
`endif
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    load       = 1'b1;
                    fw_nxt     = f_start;
                    ph_nxt     = phase_in;
                    strobe_nxt = 1'b1;
                    cnt_nxt    = (dwell == '0) ? ONE : dwell;
                    state_nxt  = DWELL;
`ifdef DDS_SWEEP_BIDIR_EN
                    dir_nxt    = 1'b0;
`endif
                end
            end
            DWELL: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (ce_in) begin
                    cnt_nxt = cnt - ONE;
                    if (cnt == ONE) state_nxt = STEP;
                end
            end
            STEP: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt  = DWELL;
                    strobe_nxt = 1'b1;
                    cnt_nxt    = reload;
`ifdef DDS_SWEEP_BIDIR_EN
                    // Turnarounds take the opposite-direction step at once, so the end
                    // frequency is never dwelt on twice.
                    if (dir_down) begin
                        if (dn_ok) fw_nxt = dn_diff[FW-1:0];
                        else if (rep_sh) begin
                            dir_nxt = 1'b0;
                            fw_nxt  = up_ok ? up_sum[FW-1:0] : start_sh;
                        end else end_sweep = 1'b1;
                    end else if (up_ok) fw_nxt = up_sum[FW-1:0];
                    else if (bidir_sh && dn_ok) begin
                        dir_nxt = 1'b1;
                        fw_nxt  = dn_diff[FW-1:0];
                    end else if (rep_sh) fw_nxt = start_sh;
                    else end_sweep = 1'b1;
`else
                    if (up_ok) fw_nxt = up_sum[FW-1:0];
                    else if (rep_sh) fw_nxt = start_sh;
                    else end_sweep = 1'b1;
`endif
                    if (end_sweep) begin
                        state_nxt  = DONE;
                        strobe_nxt = 1'b0;
                        cnt_nxt    = cnt;
                        fw_nxt     = freqword;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule
